// File: rtl/board_ram_pkg.sv
// board_ram_pkg: shared types and constants for the Trax board store
// controller. The state set depends on BOARD_RAM_CLEAR_EN (clear engine).
package board_ram_pkg;
  localparam int SRAM_W  = 16;
  localparam int NIBBLES = 4;
  localparam int DEPTH   = 19;
  // Top client address bit selects the mark plane (1) or the board plane (0)
  localparam int MARK_BIT  = DEPTH;
  // Words in the mark plane, all of which a clear rewrites
  localparam int CLR_WORDS = 2**(DEPTH-2);

  function automatic int clr_words(input int d);
    return 2**(d-2);
  endfunction

`ifdef BOARD_RAM_CLEAR_EN
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR1, S_WR2, S_CLR_W, S_CLR_H} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR1, S_WR2} state_e;
`endif
endpackage

// File: rtl/board_ram_if.sv
// board_ram_if: client tile port plus split-bus SRAM pins.
// slave = the controller, master = client/SRAM side.
interface board_ram_if #(parameter int depth = 19);
  logic [depth:0]                     ram_addr;
  logic [3:0]                         ram_wdata;
  logic                               ram_write_en;
  logic [3:0]                         ram_rdata;
  logic                               ram_ready;
  logic                               clear;
  logic                               clear_done;
  logic [depth-2:0]                   sram_addr;
  logic [board_ram_pkg::SRAM_W-1:0]   sram_dq_in;
  logic [board_ram_pkg::SRAM_W-1:0]   sram_dq_out;
  logic                               sram_dq_oe;
  logic                               sram_we_n;
  logic                               sram_oe_n;

  modport master (
    output ram_addr, ram_wdata, ram_write_en, clear, sram_dq_in,
    input  ram_rdata, ram_ready, clear_done, sram_addr, sram_dq_out,
           sram_dq_oe, sram_we_n, sram_oe_n
  );

  modport slave (
    input  ram_addr, ram_wdata, ram_write_en, clear, sram_dq_in,
    output ram_rdata, ram_ready, clear_done, sram_addr, sram_dq_out,
           sram_dq_oe, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/board_ram_ctrl_nibble_merge.sv
// nibble_merge: replace one 4-bit nibble of a word (pure combinational).
module nibble_merge #(parameter int W = 16) (
  input  logic [W-1:0] i_word,
  input  logic [1:0]   i_idx,
  input  logic [3:0]   i_nib,
  output logic [W-1:0] o_word
);
  // Copy the word, then overwrite the selected nibble
  always_comb begin
    o_word = i_word;
    o_word[4*i_idx +: 4] = i_nib;
  end
endmodule

// File: rtl/board_ram_ctrl.sv
// board_ram_ctrl: 4-bit tile port onto a 16-bit async-read SRAM, four tiles
// per word, writes as read-modify-write. Optional mark-plane clear engine
// is built when BOARD_RAM_CLEAR_EN is defined.
module board_ram_ctrl
  import board_ram_pkg::*;
#(
  parameter int depth  = 19,
  parameter int sram_w = SRAM_W
) (
  input  logic      clk,
  input  logic      reset,
  board_ram_if.slave bus
);
  localparam int WA = depth - 1;

  state_e            r_state, w_next;
  logic [WA-1:0]     r_waddr;
  logic [1:0]        r_nib;
  logic [3:0]        r_wdata;
  logic [3:0]        r_rdata;
  logic [sram_w-1:0] r_buf;
  logic [sram_w-1:0] w_merged;
  logic              r_ready;

`ifdef BOARD_RAM_CLEAR_EN
  localparam int CW_BITS = $clog2(clr_words(depth));
  logic [CW_BITS-1:0] r_cnt;
  logic               r_done;
`else
  logic w_unused_clear;
  assign w_unused_clear = bus.clear;
`endif

  nibble_merge #(.W(sram_w)) u_merge (
    .i_word (r_buf),
    .i_idx  (r_nib),
    .i_nib  (r_wdata),
    .o_word (w_merged)
  );

  // State register; reset drops straight to IDLE so strobes release at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and SRAM pin drive, all decoded from the current state
  always_comb begin
    w_next          = r_state;
    bus.sram_addr   = bus.ram_addr[depth:2];
    bus.sram_oe_n   = 1'b1;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_we_n   = 1'b1;
    bus.sram_dq_out = '0;
    case (r_state)
      S_IDLE: begin
        bus.sram_oe_n = 1'b0;
        if (bus.ram_write_en) w_next = S_RD;
`ifdef BOARD_RAM_CLEAR_EN
        else if (bus.clear)   w_next = S_CLR_W;
`endif
      end
      S_RD: begin
        bus.sram_addr = r_waddr;
        bus.sram_oe_n = 1'b0;
        w_next        = S_WR1;
      end
      S_WR1: begin
        bus.sram_addr   = r_waddr;
        bus.sram_dq_oe  = 1'b1;
        bus.sram_we_n   = 1'b0;
        bus.sram_dq_out = w_merged;
        w_next          = S_WR2;
      end
      S_WR2: begin
        // we_n has risen; keep driving data for hold time
        bus.sram_addr   = r_waddr;
        bus.sram_dq_oe  = 1'b1;
        bus.sram_dq_out = w_merged;
        w_next          = S_IDLE;
      end
`ifdef BOARD_RAM_CLEAR_EN
      S_CLR_W: begin
        bus.sram_addr  = {1'b1, r_cnt};
        bus.sram_dq_oe = 1'b1;
        bus.sram_we_n  = 1'b0;
        w_next         = S_CLR_H;
      end
      S_CLR_H: begin
        bus.sram_addr  = {1'b1, r_cnt};
        bus.sram_dq_oe = 1'b1;
        w_next         = (&r_cnt) ? S_IDLE : S_CLR_W;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Capture write request in IDLE; latch the old word during RD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waddr <= '0;
      r_nib   <= '0;
      r_wdata <= '0;
      r_buf   <= '0;
    end else begin
      if (r_state == S_IDLE && bus.ram_write_en) begin
        r_waddr <= bus.ram_addr[depth:2];
        r_nib   <= bus.ram_addr[1:0];
        r_wdata <= bus.ram_wdata;
      end
      if (r_state == S_RD) r_buf <= bus.sram_dq_in;
    end
  end

  // Read tile tracks the held address while idle; ready mirrors next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
      r_ready <= 1'b1;
    end else begin
      if (r_state == S_IDLE) r_rdata <= bus.sram_dq_in[4*bus.ram_addr[1:0] +: 4];
      r_ready <= (w_next == S_IDLE);
    end
  end

`ifdef BOARD_RAM_CLEAR_EN
  // Clear word counter; done flag drops on start, rises on counter wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (r_state == S_IDLE && bus.clear && !bus.ram_write_en) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (r_state == S_CLR_H) begin
      r_cnt <= r_cnt + 1'b1;
      if (&r_cnt) r_done <= 1'b1;
    end
  end
  assign bus.clear_done = r_done;
`else
  assign bus.clear_done = 1'b1;
`endif

  assign bus.ram_rdata = r_rdata;
  assign bus.ram_ready = r_ready;
endmodule
